// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator memory controller.
package calc_pkg;

  // One BCD digit.
  typedef logic [3:0] bcd_t;

  // Largest legal BCD digit value.
  localparam bcd_t BCD_MAX = 4'd9;

  // Controller FSM states.
  typedef enum logic [1:0] {
    IDLE,
    STORE,
    RECALL
  } state_t;

endpackage : calc_pkg

// File: rtl/bcd_shift_reg.sv
// DIGITS-nibble BCD register: shift-left-in, shift-right, parallel clear,
// plus a single-nibble write port used for serial recall.
// Priority when several controls are high: clr > wr > shl > shr.
module bcd_shift_reg
  import calc_pkg::*;
#(
  parameter int DIGITS = 4,
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clr_i,
  input  logic                  shl_i,
  input  logic                  shr_i,
  input  logic [3:0]            din_i,
  input  logic                  wr_i,
  input  logic [IW-1:0]         wr_idx_i,
  input  logic [3:0]            wr_data_i,
  output logic [4*DIGITS-1:0]   q_o
);

  bcd_t [DIGITS-1:0] q_q, q_d;

  // Next-state selection for the nibble register.
  // NOTE: q_d is given a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (wr_i) begin
      q_d[wr_idx_i] = wr_data_i;
    end else if (shl_i) begin
      q_d = {q_q[DIGITS-2:0], din_i};
    end else if (shr_i) begin
      q_d = {bcd_t'(0), q_q[DIGITS-1:1]};
    end
  end

  // Register the nibbles; cleared on reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule : bcd_shift_reg

// File: rtl/calc_mem_ctrl.sv
// Calculator entry buffer with a one-register BCD memory (MS/MR/MC).
// MS and MR move the value serially, one nibble per cycle, digit 0 first.
// Optional feature: define CALC_MEM_FLAG_EN to add the mem_flag output.
module calc_mem_ctrl
  import calc_pkg::*;
#(
  parameter int DIGITS = 4,
  localparam int LW = $clog2(DIGITS + 1),
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                digit_strobe,
  input  logic [3:0]          digit_in,
  input  logic                bksp_strobe,
  input  logic                MS_strobe,
  input  logic                MR_strobe,
  input  logic                MC_strobe,
  output logic [4*DIGITS-1:0] entry,
  output logic [LW-1:0]       entry_len,
  output logic                busy,
  output logic                error
`ifdef CALC_MEM_FLAG_EN
  ,
  output logic                mem_flag
`endif
);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     mem_len_q, mem_len_d;
  bcd_t [DIGITS-1:0] mem_q, mem_d;
  bcd_t [DIGITS-1:0] entry_n;
  logic              error_q, error_d;
  logic              shl, shr, wr;
  logic              last_cnt;

  assign entry_n  = entry;
  assign last_cnt = (cnt_q == CW'(DIGITS - 1));

  bcd_shift_reg #(.DIGITS(DIGITS)) u_entry (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (1'b0),
    .shl_i     (shl),
    .shr_i     (shr),
    .din_i     (digit_in),
    .wr_i      (wr),
    .wr_idx_i  (cnt_q),
    .wr_data_i (mem_q[cnt_q]),
    .q_o       (entry)
  );

  // FSM next state, transfer sequencing and entry-buffer controls.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    mem_d     = mem_q;
    mem_len_d = mem_len_q;
    error_d   = 1'b0;
    shl       = 1'b0;
    shr       = 1'b0;
    wr        = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Strict priority: MC > MS > MR > bksp > digit; the rest are dropped.
        if (MC_strobe) begin
          mem_d     = '0;
          mem_len_d = '0;
        end else if (MS_strobe) begin
          state_d = STORE;
        end else if (MR_strobe) begin
          state_d = RECALL;
        end else if (bksp_strobe) begin
          if (len_q != '0) begin
            shr   = 1'b1;
            len_d = len_q - LW'(1);
          end
        end else if (digit_strobe) begin
          if ((len_q < LW'(DIGITS)) && (digit_in <= BCD_MAX)) begin
            shl   = 1'b1;
            len_d = len_q + LW'(1);
          end else begin
            error_d = 1'b1;
          end
        end
      end
      STORE: begin
        mem_d[cnt_q] = entry_n[cnt_q];
        if (last_cnt) begin
          mem_len_d = len_q;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RECALL: begin
        wr = 1'b1;
        if (last_cnt) begin
          len_d   = mem_len_q;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, length, memory and error registers.
  // NOTE: the memory is only DIGITS nibbles of flops, so it is reset; its cleared value is visible through MR.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      mem_q     <= '0;
      mem_len_q <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      mem_q     <= mem_d;
      mem_len_q <= mem_len_d;
      error_q   <= error_d;
    end
  end

  assign entry_len = len_q;
  assign busy      = (state_q != IDLE);
  assign error     = error_q;

`ifdef CALC_MEM_FLAG_EN
  logic mem_flag_q;

  // Flag set when a STORE completes, cleared by an honoured MC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_flag_q <= 1'b0;
    end else if ((state_q == IDLE) && MC_strobe) begin
      mem_flag_q <= 1'b0;
    end else if ((state_q == STORE) && last_cnt) begin
      mem_flag_q <= 1'b1;
    end
  end

  assign mem_flag = mem_flag_q;
`endif

endmodule : calc_mem_ctrl

// File: tb/tb_calc_mem_ctrl.sv
// Scoreboard bench for calc_mem_ctrl (DIGITS=4): stimulus pushes the
// reference model's expected outputs, a monitor pops and compares each cycle.
module tb_calc_mem_ctrl;

  localparam int D = 4;
`ifdef CALC_MEM_FLAG_EN
  localparam bit FLAG_EN = 1'b1;
`else
  localparam bit FLAG_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        digit_strobe = 1'b0;
  logic [3:0]  digit_in = 4'd0;
  logic        bksp_strobe = 1'b0;
  logic        MS_strobe = 1'b0;
  logic        MR_strobe = 1'b0;
  logic        MC_strobe = 1'b0;
  logic [15:0] entry;
  logic [2:0]  entry_len;
  logic        busy;
  logic        error;
  logic        flag_o;

  calc_mem_ctrl #(.DIGITS(D)) dut (
    .clock        (clock),
    .reset        (reset),
    .digit_strobe (digit_strobe),
    .digit_in     (digit_in),
    .bksp_strobe  (bksp_strobe),
    .MS_strobe    (MS_strobe),
    .MR_strobe    (MR_strobe),
    .MC_strobe    (MC_strobe),
    .entry        (entry),
    .entry_len    (entry_len),
    .busy         (busy),
    .error        (error)
`ifdef CALC_MEM_FLAG_EN
    ,
    .mem_flag     (flag_o)
`endif
  );

`ifndef CALC_MEM_FLAG_EN
  assign flag_o = 1'b0;
`endif

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  logic [21:0] exp_q[$];

  // Reference model: value-level view of entry and memory.
  logic [15:0] m_entry, m_mem;
  int          m_len, m_mlen, m_left;
  bit          m_rec, m_flag, m_err;

  function automatic logic [21:0] observed();
    return {entry, entry_len, busy, error, flag_o};
  endfunction

  function automatic logic [21:0] expected();
    return {m_entry, 3'(m_len), (m_left > 0), m_err, FLAG_EN & m_flag};
  endfunction

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got entry=%h len=%0d busy=%b err=%b flag=%b, expected entry=%h len=%0d busy=%b err=%b flag=%b",
               name, act[21:6], act[5:3], act[2], act[1], act[0],
               exp[21:6], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic model_reset();
    m_entry = '0; m_mem = '0; m_len = 0; m_mlen = 0;
    m_left = 0; m_rec = 0; m_flag = 0; m_err = 0;
  endtask

  task automatic model_step(input bit ds, input logic [3:0] d, input bit bk,
                            input bit ms, input bit mr, input bit mc);
    logic [31:0] mask;
    int k;
    m_err = 0;
    if (m_left > 0) begin
      k = D - m_left;
      if (m_rec) begin
        // After recall cycle k, digits 0..k hold memory digits.
        mask = (32'h1 << (4 * (k + 1))) - 32'h1;
        m_entry = (m_entry & ~mask[15:0]) | (m_mem & mask[15:0]);
        if (m_left == 1) m_len = m_mlen;
      end else if (m_left == 1) begin
        m_mem = m_entry; m_mlen = m_len; m_flag = 1;
      end
      m_left--;
    end else if (mc) begin
      m_mem = '0; m_mlen = 0; m_flag = 0;
    end else if (ms) begin
      m_left = D; m_rec = 0;
    end else if (mr) begin
      m_left = D; m_rec = 1;
    end else if (bk) begin
      if (m_len > 0) begin
        m_entry = m_entry >> 4; m_len--;
      end
    end else if (ds) begin
      if (m_len < D && d <= 4'd9) begin
        m_entry = {m_entry[11:0], d}; m_len++;
      end else begin
        m_err = 1;
      end
    end
  endtask

  // Apply one cycle of inputs and queue the model's post-edge outputs.
  task automatic drive(input bit ds, input logic [3:0] d, input bit bk,
                       input bit ms, input bit mr, input bit mc);
    @(negedge clock);
    digit_strobe = ds; digit_in = d; bksp_strobe = bk;
    MS_strobe = ms; MR_strobe = mr; MC_strobe = mc;
    model_step(ds, d, bk, ms, mr, mc);
    exp_q.push_back(expected());
  endtask

  task automatic digit(input logic [3:0] d);
    drive(1, d, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 4'd0, 0, 0, 0, 0);
  endtask

  // Monitor: compare DUT outputs with the oldest queued expectation.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) check($sformatf("vec%0d", vectors), observed(), exp_q.pop_front());
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    #1 check("reset_state", observed(), 22'h0);
    @(negedge clock);
    reset = 1'b0;

    // Digits 1,2,3 -> 0x0123.
    digit(1); digit(2); digit(3);
    // Backspace four times, the last two on short/empty entries.
    repeat (4) drive(0, 4'd0, 1, 0, 0, 0);
    // Fill to 0x1234, overflow digit, empty, then illegal digit 0xA.
    digit(1); digit(2); digit(3); digit(4); digit(5); idle(1);
    repeat (4) drive(0, 4'd0, 1, 0, 0, 0);
    digit(4'hA); idle(1);
    // Store 0x0042, clear entry, recall.
    digit(4); digit(2);
    drive(0, 4'd0, 0, 1, 0, 0); idle(5);
    repeat (2) drive(0, 4'd0, 1, 0, 0, 0);
    drive(0, 4'd0, 0, 0, 1, 0); idle(5);
    // Strobes while busy are ignored.
    drive(0, 4'd0, 0, 0, 1, 0);
    drive(1, 4'd7, 1, 1, 0, 1); drive(1, 4'hB, 0, 0, 1, 0); idle(4);
    // MS and MC together: only MC; later MR recalls zero.
    drive(0, 4'd0, 0, 1, 0, 1); idle(2);
    drive(0, 4'd0, 0, 0, 1, 0); idle(5);
    // Simultaneous bksp+digit on empty entry: bksp wins, no error.
    drive(1, 4'hC, 1, 0, 0, 0); idle(1);
    // Reset in the second STORE cycle after a completed store.
    digit(4); digit(2);
    drive(0, 4'd0, 0, 1, 0, 0); idle(5);
    drive(0, 4'd0, 0, 1, 0, 0); idle(1);
    @(negedge clock);
    reset = 1'b1;
    #1 check("reset_mid_store", observed(), 22'h0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    drive(0, 4'd0, 0, 0, 1, 0); idle(5);
    digit(5); drive(0, 4'd0, 0, 1, 0, 0); idle(5);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 2) == 0, 4'($urandom_range(0, 11)),
            $urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0);
    end
    idle(2);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clock);
    #2;
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_calc_mem_ctrl
